// File: rtl/mult_unit.sv
// mult_unit: sequential shift-add multiplier, one multiplier bit per cycle.
// Holds the X/A/B register chain; signed mode subtracts on the final bit.
module mult_unit #(
    parameter int WIDTH  = 8,
    parameter int SIGNED = 1
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 Start,
    input  logic [WIDTH-1:0]     Multiplicand,
    input  logic [WIDTH-1:0]     Multiplier,
    output logic                 X,
    output logic [WIDTH-1:0]     A,
    output logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   Product,
    output logic                 Busy,
    output logic                 Done
);

    localparam int       CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam bit       SG   = (SIGNED != 0);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE,
        HOLD
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [WIDTH-1:0]  s_reg;
    logic [CW-1:0]     cnt;
    logic              m;
    logic              last;
    logic              load;
    logic              step;
    logic [WIDTH:0]    acc;
    logic [WIDTH:0]    addend;
    logic [WIDTH:0]    sum;

    // Add phase: accumulate, or subtract the multiplicand on the sign bit.
    always_comb begin
        m      = B[0];
        last   = (cnt == LAST);
        addend = SG ? {s_reg[WIDTH-1], s_reg} : {1'b0, s_reg};
        acc    = SG ? {X, A} : {1'b0, A};
        sum    = acc;
        if (m) begin
            if (SG && last) begin
                sum = acc - addend;
            end else begin
                sum = acc + addend;
            end
        end
    end

    // Next-state and step control; Start must drop before a new multiply.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = Start ? HOLD : IDLE;
            end
            HOLD: begin
                if (!Start) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Register chain: load operands, then shift {X',A',B} right once per step.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            X     <= 1'b0;
            A     <= '0;
            B     <= '0;
            s_reg <= '0;
            cnt   <= '0;
        end else if (load) begin
            X     <= 1'b0;
            A     <= '0;
            B     <= Multiplier;
            s_reg <= Multiplicand;
            cnt   <= '0;
        end else if (step) begin
            X   <= SG ? sum[WIDTH] : 1'b0;
            A   <= {sum[WIDTH], sum[WIDTH-1:1]};
            B   <= {sum[0], B[WIDTH-1:1]};
            cnt <= last ? cnt : cnt + CW'(1);
        end
    end

    assign Product = {A, B};
    assign Busy    = (state_q == RUN);
    assign Done    = (state_q == DONE);

endmodule

// File: tb/tb_mult_unit.sv
// tb_mult_unit: three multiplier configurations against a cycle model.
// Directed vectors with literal products and latencies.
module tb_mult_unit;

    logic        Clk;
    logic        Reset_n;
    logic [2:0]  st;
    logic [15:0] opa [3];
    logic [15:0] opb [3];

    logic        x0, x1, x2;
    logic [7:0]  a0, b0, a1, b1;
    logic [15:0] a2, b2;
    logic [15:0] p0, p1;
    logic [31:0] p2;
    logic        bs0, bs1, bs2, dn0, dn1, dn2;

    logic [31:0] pr [3];
    logic [31:0] ab [3];
    logic        xv [3];
    logic        bs [3];
    logic        dn [3];

    int errors = 0;
    int checks = 0;

    int  W  [3] = '{8, 8, 16};
    bit  SGv[3] = '{1'b1, 1'b0, 1'b1};
    int          t   [3];
    bit          hold[3];
    logic [31:0] ep  [3];
    bit          ex  [3];

    mult_unit #(.WIDTH(8), .SIGNED(1)) u0 (
        .Clk(Clk), .Reset_n(Reset_n), .Start(st[0]),
        .Multiplicand(opa[0][7:0]), .Multiplier(opb[0][7:0]),
        .X(x0), .A(a0), .B(b0), .Product(p0), .Busy(bs0), .Done(dn0)
    );
    mult_unit #(.WIDTH(8), .SIGNED(0)) u1 (
        .Clk(Clk), .Reset_n(Reset_n), .Start(st[1]),
        .Multiplicand(opa[1][7:0]), .Multiplier(opb[1][7:0]),
        .X(x1), .A(a1), .B(b1), .Product(p1), .Busy(bs1), .Done(dn1)
    );
    mult_unit #(.WIDTH(16), .SIGNED(1)) u2 (
        .Clk(Clk), .Reset_n(Reset_n), .Start(st[2]),
        .Multiplicand(opa[2]), .Multiplier(opb[2]),
        .X(x2), .A(a2), .B(b2), .Product(p2), .Busy(bs2), .Done(dn2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always_comb begin
        pr[0] = {16'b0, p0};
        pr[1] = {16'b0, p1};
        pr[2] = p2;
        ab[0] = {16'b0, a0, b0};
        ab[1] = {16'b0, a1, b1};
        ab[2] = {a2, b2};
        xv[0] = x0; xv[1] = x1; xv[2] = x2;
        bs[0] = bs0; bs[1] = bs1; bs[2] = bs2;
        dn[0] = dn0; dn[1] = dn1; dn[2] = dn2;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference product by plain integer arithmetic.
    function automatic logic [31:0] mdl(input int w, input bit sg,
                                        input logic [15:0] a,
                                        input logic [15:0] b);
        longint x, y, msk, p;
        msk = (longint'(1) << w) - 1;
        x = longint'(a) & msk;
        y = longint'(b) & msk;
        if (sg && a[w-1]) x = x - (longint'(1) << w);
        if (sg && b[w-1]) y = y - (longint'(1) << w);
        p = (x * y) & ((longint'(1) << (2 * w)) - 1);
        return 32'(p);
    endfunction

    // Timing model: t = cycles since accepted start, hold = Start still high.
    always @(posedge Clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!Reset_n) begin
                t[i] = 0; hold[i] = 0; ep[i] = '0; ex[i] = 0;
            end else if (t[i] >= 1 && t[i] <= W[i]) begin
                t[i] = t[i] + 1;
            end else if (t[i] == W[i] + 1) begin
                t[i] = 0;
                hold[i] = st[i];
            end else if (hold[i]) begin
                if (!st[i]) hold[i] = 0;
            end else if (st[i]) begin
                t[i] = 1;
                ep[i] = mdl(W[i], SGv[i], opa[i], opb[i]);
                ex[i] = SGv[i] ? ep[i][2*W[i]-1] : 1'b0;
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge Clk) begin
        if (Reset_n) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("busy%0d", i), 32'(bs[i]),
                    32'(t[i] >= 1 && t[i] <= W[i]));
                chk($sformatf("done%0d", i), 32'(dn[i]),
                    32'(t[i] == W[i] + 1));
                chk($sformatf("prod_ab%0d", i), pr[i], ab[i]);
                if (t[i] == 0 || t[i] == W[i] + 1) begin
                    chk($sformatf("prod%0d", i), pr[i], ep[i]);
                    chk($sformatf("x%0d", i), 32'(xv[i]), 32'(ex[i]));
                end
            end
        end
    end

    task automatic mul(input int i, input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] lit, input bit litx, input int lat);
        int n;
        @(posedge Clk); #1;
        opa[i] = a; opb[i] = b; st[i] = 1'b1;
        @(posedge Clk); #1;
        st[i] = 1'b0;
        opa[i] = 16'($urandom);
        opb[i] = 16'($urandom);
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (!dn[i] && n < 60);
        chk($sformatf("lat%0d_%h_%h", i, a, b), 32'(n), 32'(lat));
        chk($sformatf("lit%0d_%h_%h", i, a, b), pr[i], lit);
        chk($sformatf("litx%0d_%h_%h", i, a, b), 32'(xv[i]), 32'(litx));
    endtask

    initial begin
        int nd;
        Reset_n = 1'b0;
        st = '0;
        for (int i = 0; i < 3; i++) begin
            opa[i] = '0; opb[i] = '0; t[i] = 0; hold[i] = 0; ep[i] = '0; ex[i] = 0;
        end
        chk("mdl_pin_a", mdl(8, 1'b1, 16'h07, 16'hFD), 32'hFFEB);
        chk("mdl_pin_b", mdl(8, 1'b0, 16'hFF, 16'hFF), 32'hFE01);
        chk("mdl_pin_c", mdl(16, 1'b1, 16'h7FFF, 16'h8000), 32'hC0008000);
        repeat (3) @(posedge Clk);
        #1 Reset_n = 1'b1;
        @(negedge Clk);
        chk("rst_p0", pr[0], 32'h0);
        chk("rst_p2", pr[2], 32'h0);
        chk("rst_busy", 32'(bs0), 32'h0);
        chk("rst_done", 32'(dn0), 32'h0);

        mul(0, 16'h07, 16'hFD, 32'hFFEB, 1'b1, 9);
        mul(0, 16'h80, 16'h80, 32'h4000, 1'b0, 9);
        mul(0, 16'hFF, 16'hFF, 32'h0001, 1'b0, 9);
        mul(0, 16'h00, 16'h5A, 32'h0000, 1'b0, 9);
        mul(0, 16'h7F, 16'h80, 32'hC080, 1'b1, 9);
        mul(1, 16'hFF, 16'hFF, 32'hFE01, 1'b0, 9);
        mul(1, 16'h80, 16'h02, 32'h0100, 1'b0, 9);
        mul(2, 16'h7FFF, 16'h8000, 32'hC0008000, 1'b1, 17);

        @(posedge Clk); #1;
        opa[0] = 16'h05; opb[0] = 16'h06; st[0] = 1'b1;
        nd = 0;
        repeat (40) begin
            @(negedge Clk);
            if (dn0) nd++;
        end
        chk("hold_one_done", 32'(nd), 32'd1);
        chk("hold_prod", pr[0], 32'h001E);
        @(posedge Clk); #1 st[0] = 1'b0;
        repeat (3) @(posedge Clk);

        @(posedge Clk); #1;
        opa[0] = 16'h11; opb[0] = 16'h22; st[0] = 1'b1;
        @(posedge Clk); #1 st[0] = 1'b0;
        repeat (4) @(negedge Clk);
        chk("pre_rst_busy", 32'(bs0), 32'h1);
        Reset_n = 1'b0;
        #1;
        chk("arst_ab", ab[0], 32'h0);
        chk("arst_x", 32'(x0), 32'h0);
        chk("arst_busy", 32'(bs0), 32'h0);
        chk("arst_done", 32'(dn0), 32'h0);
        @(posedge Clk); #1 Reset_n = 1'b1;
        nd = 0;
        repeat (20) begin
            @(negedge Clk);
            if (dn0) nd++;
        end
        chk("rst_no_done", 32'(nd), 32'd0);
        mul(0, 16'h11, 16'h22, 32'h0242, 1'b0, 9);
        repeat (5) @(posedge Clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
